// File: rtl/vx_execute_gather_pkg.sv
// Shared widths, gather FSM state and warp header record for the execute gather block.
package vx_execute_gather_pkg;
  localparam int NUM_THREADS   = 4;
  localparam int XLEN          = 32;
  localparam int UUID_WIDTH    = 16;
  localparam int NW_WIDTH      = 2;
  localparam int PC_WIDTH      = 32;
  localparam int OP_TYPE_WIDTH = 4;
  localparam int OP_ARGS_WIDTH = 8;
  localparam int NR_WIDTH      = 5;
  localparam int NT_WIDTH      = 2;
  localparam int CU_ID_WIDTH   = 2;

  typedef enum logic [1:0] {
    GATHER_IDLE    = 2'd0,
    GATHER_COLLECT = 2'd1,
    GATHER_FULL    = 2'd2
  } gather_state_e;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]    uuid;
    logic [NW_WIDTH-1:0]      wid;
    logic [PC_WIDTH-1:0]      pc;
    logic [OP_TYPE_WIDTH-1:0] op_type;
    logic [OP_ARGS_WIDTH-1:0] op_args;
    logic                     wb;
    logic [NR_WIDTH-1:0]      rd;
    logic [NT_WIDTH-1:0]      tid;
    logic [CU_ID_WIDTH-1:0]   cu_id;
  } gather_hdr_t;

  // Beats per full warp for a given input lane count.
  function automatic int pid_count(input int num_lanes);
    return NUM_THREADS / num_lanes;
  endfunction

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vx_gather_lane_buf.sv
// Full-warp lane register array; each input beat lands in the lanes selected by its pid.
module vx_gather_lane_buf
  import vx_execute_gather_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int PID_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [PID_WIDTH-1:0]        wr_pid,
  input  logic [NUM_LANES-1:0]        wr_tmask,
  input  logic [NUM_LANES*XLEN-1:0]   wr_rs1_data,
  input  logic [NUM_LANES*XLEN-1:0]   wr_rs2_data,
  input  logic [NUM_LANES*XLEN-1:0]   wr_rs3_data,
  output logic [NUM_THREADS-1:0]      tmask,
  output logic [NUM_THREADS*XLEN-1:0] rs1_data,
  output logic [NUM_THREADS*XLEN-1:0] rs2_data,
  output logic [NUM_THREADS*XLEN-1:0] rs3_data
);
  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
    localparam int LANE = gi % NUM_LANES;
    localparam int PID  = gi / NUM_LANES;

    logic            sel;
    logic            tmask_reg;
    logic [XLEN-1:0] rs1_reg, rs2_reg, rs3_reg;

    assign sel = wr_en && (wr_pid == PID_WIDTH'(PID));

    // The write takes priority so a clear-and-write beat leaves its own lanes populated.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        tmask_reg <= 1'b0;
      end else if (sel) begin
        tmask_reg <= wr_tmask[LANE];
      end else if (clear) begin
        tmask_reg <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (sel) begin
        rs1_reg <= wr_rs1_data[LANE*XLEN +: XLEN];
        rs2_reg <= wr_rs2_data[LANE*XLEN +: XLEN];
        rs3_reg <= wr_rs3_data[LANE*XLEN +: XLEN];
      end else if (clear) begin
        rs1_reg <= '0;
        rs2_reg <= '0;
        rs3_reg <= '0;
      end
    end

    assign tmask[gi]                  = tmask_reg;
    assign rs1_data[gi*XLEN +: XLEN]  = rs1_reg;
    assign rs2_data[gi*XLEN +: XLEN]  = rs2_reg;
    assign rs3_data[gi*XLEN +: XLEN]  = rs3_reg;
  end
endmodule

// File: rtl/vx_execute_gather.sv
// Reassembles pid-indexed partial-warp beats into a single full-warp record.
module vx_execute_gather
  import vx_execute_gather_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int PID_WIDTH = log2up(pid_count(NUM_LANES))
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        execute_in_valid,
  input  logic [UUID_WIDTH-1:0]       execute_in_uuid,
  input  logic [NW_WIDTH-1:0]         execute_in_wid,
  input  logic [NUM_LANES-1:0]        execute_in_tmask,
  input  logic [PC_WIDTH-1:0]         execute_in_pc,
  input  logic [OP_TYPE_WIDTH-1:0]    execute_in_op_type,
  input  logic [OP_ARGS_WIDTH-1:0]    execute_in_op_args,
  input  logic                        execute_in_wb,
  input  logic [NR_WIDTH-1:0]         execute_in_rd,
  input  logic [NT_WIDTH-1:0]         execute_in_tid,
  input  logic [CU_ID_WIDTH-1:0]      execute_in_cu_id,
  input  logic [NUM_LANES*XLEN-1:0]   execute_in_rs1_data,
  input  logic [NUM_LANES*XLEN-1:0]   execute_in_rs2_data,
  input  logic [NUM_LANES*XLEN-1:0]   execute_in_rs3_data,
  input  logic [PID_WIDTH-1:0]        execute_in_pid,
  input  logic                        execute_in_sop,
  input  logic                        execute_in_eop,
  output logic                        execute_in_ready,
  output logic                        execute_out_valid,
  output logic [UUID_WIDTH-1:0]       execute_out_uuid,
  output logic [NW_WIDTH-1:0]         execute_out_wid,
  output logic [NUM_THREADS-1:0]      execute_out_tmask,
  output logic [PC_WIDTH-1:0]         execute_out_pc,
  output logic [OP_TYPE_WIDTH-1:0]    execute_out_op_type,
  output logic [OP_ARGS_WIDTH-1:0]    execute_out_op_args,
  output logic                        execute_out_wb,
  output logic [NR_WIDTH-1:0]         execute_out_rd,
  output logic [NT_WIDTH-1:0]         execute_out_tid,
  output logic [CU_ID_WIDTH-1:0]      execute_out_cu_id,
  output logic [NUM_THREADS*XLEN-1:0] execute_out_rs1_data,
  output logic [NUM_THREADS*XLEN-1:0] execute_out_rs2_data,
  output logic [NUM_THREADS*XLEN-1:0] execute_out_rs3_data,
  output logic [0:0]                  execute_out_pid,
  output logic                        execute_out_sop,
  output logic                        execute_out_eop,
  input  logic                        execute_out_ready,
  output logic                        proto_err
);
  gather_state_e state_reg, state_next, eff_state;
  gather_hdr_t   hdr_reg, in_hdr;
  logic ready_en_reg, proto_err_reg, err_next;
  logic in_fire, out_fire, buf_clear, buf_wr, hdr_load, hdr_mismatch;

  assign execute_out_valid = (state_reg == GATHER_FULL);
  assign out_fire          = execute_out_valid && execute_out_ready;
  assign execute_in_ready  = ready_en_reg && ((state_reg != GATHER_FULL) || execute_out_ready);
  assign in_fire           = execute_in_valid && execute_in_ready;
  assign hdr_mismatch      = (execute_in_wid != hdr_reg.wid) || (execute_in_uuid != hdr_reg.uuid);

  always_comb begin
    in_hdr         = '0;
    in_hdr.uuid    = execute_in_uuid;
    in_hdr.wid     = execute_in_wid;
    in_hdr.pc      = execute_in_pc;
    in_hdr.op_type = execute_in_op_type;
    in_hdr.op_args = execute_in_op_args;
    in_hdr.wb      = execute_in_wb;
    in_hdr.rd      = execute_in_rd;
    in_hdr.tid     = execute_in_tid;
    in_hdr.cu_id   = execute_in_cu_id;
  end

  // A drained FULL behaves as IDLE for a beat arriving in the same cycle.
  always_comb begin
    eff_state  = (state_reg == GATHER_FULL && out_fire) ? GATHER_IDLE : state_reg;
    state_next = eff_state;
    buf_clear  = 1'b0;
    buf_wr     = 1'b0;
    hdr_load   = 1'b0;
    err_next   = 1'b0;
    if (in_fire) begin
      if (execute_in_sop) begin
        buf_clear  = 1'b1;
        buf_wr     = 1'b1;
        hdr_load   = 1'b1;
        err_next   = (eff_state == GATHER_COLLECT);
        state_next = execute_in_eop ? GATHER_FULL : GATHER_COLLECT;
      end else if (eff_state == GATHER_COLLECT) begin
        buf_wr   = 1'b1;
        err_next = hdr_mismatch;
        if (execute_in_eop) begin
          state_next = GATHER_FULL;
        end
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= GATHER_IDLE;
      proto_err_reg <= 1'b0;
      ready_en_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      proto_err_reg <= err_next;
      ready_en_reg  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_load) begin
      hdr_reg <= in_hdr;
    end
  end

  vx_gather_lane_buf #(
    .NUM_LANES (NUM_LANES),
    .PID_WIDTH (PID_WIDTH)
  ) lane_buf (
    .clk         (clk),
    .reset       (reset),
    .clear       (buf_clear),
    .wr_en       (buf_wr),
    .wr_pid      (execute_in_pid),
    .wr_tmask    (execute_in_tmask),
    .wr_rs1_data (execute_in_rs1_data),
    .wr_rs2_data (execute_in_rs2_data),
    .wr_rs3_data (execute_in_rs3_data),
    .tmask       (execute_out_tmask),
    .rs1_data    (execute_out_rs1_data),
    .rs2_data    (execute_out_rs2_data),
    .rs3_data    (execute_out_rs3_data)
  );

  assign proto_err           = proto_err_reg;
  assign execute_out_uuid    = hdr_reg.uuid;
  assign execute_out_wid     = hdr_reg.wid;
  assign execute_out_pc      = hdr_reg.pc;
  assign execute_out_op_type = hdr_reg.op_type;
  assign execute_out_op_args = hdr_reg.op_args;
  assign execute_out_wb      = hdr_reg.wb;
  assign execute_out_rd      = hdr_reg.rd;
  assign execute_out_tid     = hdr_reg.tid;
  assign execute_out_cu_id   = hdr_reg.cu_id;
  assign execute_out_pid     = 1'b0;
  assign execute_out_sop     = 1'b1;
  assign execute_out_eop     = 1'b1;
endmodule
